pkg_read_engine: RTL
====================

PKG_READ_ENGINE -- requirements
Module: pkg_read_engine

Interface
REQ-001 Parameter ADDR_W, default 12, block address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter BLK_LOG2, default 4; words per block BLK_WORDS = 2**BLK_LOG2.
REQ-004 Parameter LEN_W, default 11, packet length field width in words.
REQ-005 iClk  in  1  sole clock; all logic rising-edge.
REQ-006 iRst  in  1  asynchronous, active-high reset.
REQ-007 iDescAddr/iDescLen/iDescDrop  in  ADDR_W/LEN_W/1  first block address, length in words (1..2**LEN_W-1), drop flag.
REQ-008 iDescVld in 1, oDescRdy out 1  descriptor handshake.
REQ-009 oLnkAddr out ADDR_W, oLnkReq out 1, iLnkData in ADDR_W, iLnkVld in 1  link-SRAM next-pointer read.
REQ-010 oMmuBlk out ADDR_W, oMmuWord out BLK_LOG2, oMmuVld out 1, iMmuRdy in 1, iMmuData in DATA_W  MMU word read; data valid exactly 1 cycle after handshake.
REQ-011 oData out DATA_W, oVld out 1, oLast out 1, iRdy in 1  packet word stream.
REQ-012 oRcvrAddr out ADDR_W, oRcvrVld out 1  block recycle, single-cycle pulse, no backpressure.
REQ-013 oBusy out 1, oDropCnt out 16  engine busy; saturating count of dropped packets.

Function
REQ-014 Block count NB = ceil(iDescLen / BLK_WORDS); tail words = iDescLen mod BLK_WORDS, 0 meaning full last block; all arithmetic unsigned, no width loss.
REQ-015 oDescRdy = 1 only in IDLE; descriptor latched on iDescVld & oDescRdy.
REQ-016 FSM states IDLE, READ, DROP, FLUSH; IDLE->READ on accepted descriptor with drop=0, IDLE->DROP with drop=1.
REQ-017 READ: on entry to each non-last block, raise oLnkReq with oLnkAddr = current block, hold until iLnkVld; captured pointer becomes next block.
REQ-018 READ: oMmuVld asserted when current block valid, pointer for a non-last block's final word already captured, and credit available.
REQ-019 Credit: output skid buffer (2 entries) occupancy plus in-flight reads SHALL never exceed 2; no data lost under any iRdy pattern.
REQ-020 oMmuWord increments per MMU handshake, wraps to 0 at block end, switching oMmuBlk to next pointer the same cycle.
REQ-021 oRcvrVld pulses with oRcvrAddr = block address on the MMU handshake of that block's last word (including the packet's final partial block).
REQ-022 After the packet's final MMU handshake, READ->FLUSH; FLUSH->IDLE when skid buffer empty and no read in flight.
REQ-023 oLast = 1 exactly on the packet's final oData word; oData/oLast held stable while oVld & !iRdy.
REQ-024 DROP: for each block, recycle its address (oRcvrVld pulse), fetch next pointer if not last; no MMU reads, no output words; DROP->IDLE after NB pulses, oDropCnt += 1 (saturate at 0xFFFF).
REQ-025 iLnkVld without oLnkReq SHALL be ignored; oLnkReq never asserted in IDLE/FLUSH.
REQ-026 iDescLen = 0 accepted and discarded: one cycle back to IDLE, no reads, no recycle, no output.
REQ-027 oBusy = (state != IDLE).

Reset
REQ-028 iRst asserted at any time returns FSM to IDLE immediately; all outputs 0, oDescRdy 1 after reset release, skid buffer emptied, oDropCnt 0, in-flight MMU data discarded.

Structure
REQ-029 Shared package pkg_read_pkg holds FSM state encoding and NB/tail helper constants.
REQ-030 Output skid buffer is sub-module pkg_read_skid (2-entry, DATA_W+1 wide).

Verification
REQ-031 Len=32, BLK_LOG2=4, iRdy=1, link returns 0x005: 32 words out, oLast on word 32, oRcvrVld for first addr then 0x005, one oLnkReq.
REQ-032 Len=19: 2 blocks, 16+3 words, second oRcvrVld on 19th MMU handshake, no oLnkReq for last block.
REQ-033 Len=40 with iRdy toggled 1-0 pseudo-randomly: output sequence identical to iMmuData order, never >2 outstanding, no word dropped or duplicated.
REQ-034 Drop desc len=48: three oRcvrVld pulses, zero oMmuVld, zero oVld, oDropCnt 0->1.
REQ-035 iLnkVld delayed 20 cycles: oMmuVld stalls before word 15 of block 0 until pointer arrives, then resumes.
REQ-036 iRst pulsed mid-READ: next cycle all outputs 0, oDescRdy 1 after release, new descriptor processed correctly.

Source files
------------

// File: rtl/pkg_read_pkg.sv
// Shared definitions for the packet read engine.
// Holds the FSM state encoding, the skid buffer depth and the helpers that
// turn a packet length into a block count and a last-block word index.
package pkg_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Number of blocks holding len words: ceil(len / 2**blk_log2).
  function automatic int unsigned blk_count(input int unsigned len,
                                            input int unsigned blk_log2);
    return (len + (32'd1 << blk_log2) - 32'd1) >> blk_log2;
  endfunction

  // Index of the final word inside the last block; a zero tail means the
  // last block is full.
  function automatic int unsigned last_word_idx(input int unsigned len,
                                                input int unsigned blk_log2);
    int unsigned tail;
    tail = len & ((32'd1 << blk_log2) - 32'd1);
    return (tail == 32'd0) ? (32'd1 << blk_log2) - 32'd1 : tail - 32'd1;
  endfunction

endpackage

// File: rtl/pkg_read_skid.sv
// Two-entry output skid buffer for the packet word stream.
// Ports:
//   iClk, iRst       clock, asynchronous active-high reset
//   iPush/iPushData  write one entry (caller guarantees space)
//   iPop             consumer ready; pops the head when oVld
//   oVld/oData       head entry, held stable until popped
//   oCnt             current occupancy (0..2)
module pkg_read_skid
  import pkg_read_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iPush,
  input  logic [W-1:0] iPushData,
  input  logic         iPop,
  output logic         oVld,
  output logic [W-1:0] oData,
  output logic [1:0]   oCnt
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign pop = iPop & (cnt_q != 2'd0);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (iPush) begin
        mem_q[wr_q] <= iPushData;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(iPush) - 2'(pop);
    end
  end

  assign oVld  = (cnt_q != 2'd0);
  assign oData = mem_q[rd_q];
  assign oCnt  = cnt_q;

endmodule

// File: rtl/pkg_read_engine.sv
// Packet read engine: walks a linked list of fixed-size blocks, reads each
// packet word through the MMU and streams it out, recycling every block
// after its last word. Drop descriptors only walk and recycle the chain.
// Ports:
//   iClk, iRst                         clock, asynchronous active-high reset
//   iDescAddr/Len/Drop, iDescVld, oDescRdy   packet descriptor
//   oLnkAddr, oLnkReq, iLnkData, iLnkVld     next-pointer read
//   oMmuBlk, oMmuWord, oMmuVld, iMmuRdy, iMmuData   word read (data +1 cycle)
//   oData, oVld, oLast, iRdy           packet word stream
//   oRcvrAddr, oRcvrVld                block recycle pulse
//   oBusy, oDropCnt                    status, saturating drop counter
module pkg_read_engine
  import pkg_read_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BLK_LOG2 = 4,
  parameter int unsigned LEN_W    = 11
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [ADDR_W-1:0]   iDescAddr,
  input  logic [LEN_W-1:0]    iDescLen,
  input  logic                iDescDrop,
  input  logic                iDescVld,
  output logic                oDescRdy,
  output logic [ADDR_W-1:0]   oLnkAddr,
  output logic                oLnkReq,
  input  logic [ADDR_W-1:0]   iLnkData,
  input  logic                iLnkVld,
  output logic [ADDR_W-1:0]   oMmuBlk,
  output logic [BLK_LOG2-1:0] oMmuWord,
  output logic                oMmuVld,
  input  logic                iMmuRdy,
  input  logic [DATA_W-1:0]   iMmuData,
  output logic [DATA_W-1:0]   oData,
  output logic                oVld,
  output logic                oLast,
  input  logic                iRdy,
  output logic [ADDR_W-1:0]   oRcvrAddr,
  output logic                oRcvrVld,
  output logic                oBusy,
  output logic [15:0]         oDropCnt
);

  localparam int unsigned CNT_W = LEN_W - BLK_LOG2 + 1;
  localparam logic [BLK_LOG2-1:0] WORD_MAX = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   blk_q;
  logic [ADDR_W-1:0]   nxt_q;
  logic                nxt_vld_q;
  logic [BLK_LOG2-1:0] word_q;
  logic [BLK_LOG2-1:0] last_idx_q;
  logic [CNT_W-1:0]    left_q;
  logic                lnk_req_q;
  logic                infl_q;
  logic                infl_last_q;
  logic [15:0]         drop_cnt_q;

  logic [CNT_W-1:0]    d_nb;
  logic [BLK_LOG2-1:0] d_last_idx;
  logic                desc_hs;
  logic                last_blk;
  logic                fin_word;
  logic                ptr_ok;
  logic                pop;
  logic [2:0]          occ_next;
  logic                credit_ok;
  logic                mmu_vld;
  logic                mmu_hs;
  logic                lnk_hs;
  logic                rcvr_vld;

  logic                skid_vld;
  logic [DATA_W:0]     skid_dout;
  logic [1:0]          skid_cnt;

  assign d_nb       = CNT_W'(blk_count(32'(iDescLen), BLK_LOG2));
  assign d_last_idx = BLK_LOG2'(last_word_idx(32'(iDescLen), BLK_LOG2));
  assign desc_hs    = iDescVld & (state_q == ST_IDLE);

  assign last_blk = (left_q == CNT_W'(1));
  assign fin_word = last_blk ? (word_q == last_idx_q) : (word_q == WORD_MAX);
  // A non-last block's final word may only be read once the next pointer is
  // held, so oMmuBlk can switch on that same handshake.
  assign ptr_ok   = last_blk | ~fin_word | nxt_vld_q;

  // Occupancy after this edge = buffered + in flight - popped now; issuing a
  // read adds one, so issue only while that stays below the buffer depth.
  assign pop       = skid_vld & iRdy;
  assign occ_next  = 3'(skid_cnt) + 3'(infl_q) - 3'(pop);
  assign credit_ok = (occ_next < 3'(SKID_DEPTH));

  assign mmu_vld = (state_q == ST_READ) & ptr_ok & credit_ok;
  assign mmu_hs  = mmu_vld & iMmuRdy;
  assign lnk_hs  = lnk_req_q & iLnkVld;

  // In DROP a non-last block is recycled only once its next pointer has been
  // read, so the link entry is never read after the block is released.
  always_comb begin
    rcvr_vld = 1'b0;
    case (state_q)
      ST_READ: rcvr_vld = mmu_hs & fin_word;
      ST_DROP: rcvr_vld = last_blk | lnk_hs;
      default: rcvr_vld = 1'b0;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      nxt_q       <= '0;
      nxt_vld_q   <= 1'b0;
      word_q      <= '0;
      last_idx_q  <= '0;
      left_q      <= '0;
      lnk_req_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      infl_q      <= mmu_hs;
      infl_last_q <= mmu_hs & fin_word & last_blk;
      case (state_q)
        ST_IDLE: begin
          if (desc_hs) begin
            blk_q      <= iDescAddr;
            left_q     <= d_nb;
            last_idx_q <= d_last_idx;
            word_q     <= '0;
            nxt_vld_q  <= 1'b0;
            lnk_req_q  <= (d_nb > CNT_W'(1));
            if (iDescLen == '0)  state_q <= ST_FLUSH;
            else if (iDescDrop)  state_q <= ST_DROP;
            else                 state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (lnk_hs) begin
            nxt_q     <= iLnkData;
            nxt_vld_q <= 1'b1;
            lnk_req_q <= 1'b0;
          end
          if (mmu_hs) begin
            if (fin_word) begin
              if (last_blk) begin
                state_q <= ST_FLUSH;
              end else begin
                blk_q     <= nxt_q;
                nxt_vld_q <= 1'b0;
                word_q    <= '0;
                left_q    <= left_q - CNT_W'(1);
                lnk_req_q <= (left_q > CNT_W'(2));
              end
            end else begin
              word_q <= word_q + BLK_LOG2'(1);
            end
          end
        end
        ST_DROP: begin
          if (last_blk) begin
            state_q <= ST_IDLE;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
          end else if (lnk_hs) begin
            blk_q     <= iLnkData;
            left_q    <= left_q - CNT_W'(1);
            lnk_req_q <= (left_q > CNT_W'(2));
          end
        end
        ST_FLUSH: begin
          if ((skid_cnt == 2'd0) && !infl_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pkg_read_skid #(.W(DATA_W + 1)) u_skid (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPush     (infl_q),
    .iPushData ({infl_last_q, iMmuData}),
    .iPop      (iRdy),
    .oVld      (skid_vld),
    .oData     (skid_dout),
    .oCnt      (skid_cnt)
  );

  assign oDescRdy  = (state_q == ST_IDLE) & ~iRst;
  assign oLnkAddr  = blk_q;
  assign oLnkReq   = lnk_req_q;
  assign oMmuBlk   = blk_q;
  assign oMmuWord  = word_q;
  assign oMmuVld   = mmu_vld;
  assign oData     = skid_dout[DATA_W-1:0];
  assign oLast     = skid_dout[DATA_W];
  assign oVld      = skid_vld;
  assign oRcvrAddr = blk_q;
  assign oRcvrVld  = rcvr_vld;
  assign oBusy     = (state_q != ST_IDLE);
  assign oDropCnt  = drop_cnt_q;

endmodule
